sliding_window: RTL and testbench
=================================

Name: sliding_window

Overview:
Streaming moving-average filter over the most recent L signed samples. Each accepted input sample updates a running window sum. The block emits the window mean on a registered output with a one-cycle valid pulse. It sits in the sample datapath between a producer of sporadic valid-qualified samples and downstream logging/processing logic.

Parameters:
WIDTH, 32, bit width of signed input samples and of the averaged output.
L, 4, window length in samples; must be a power of two and at least 2. Elaboration error otherwise.

Ports:
clk  input  1  rising-edge clock, sole clock domain.
rst  input  1  reset, synchronous and active-high.
in_valid  input  1  qualifies in_sample; one sample accepted per cycle where high.
in_sample  input  WIDTH  signed two's-complement input sample.
out_valid  output  1  one-cycle pulse; out_avg holds a new valid average.
out_avg  output  WIDTH  signed window mean, registered.

Behaviour:
- Reset (rst=1 at posedge):
  - All L window slots cleared to 0, running sum 0, fill counter 0, write pointer 0.
  - out_valid=0, out_avg=0.
  - Reset mid-stream discards all history; the warm-up restarts.
- No backpressure: every cycle with in_valid=1 consumes in_sample. Cycles with in_valid=0 change nothing, except that out_valid drops to 0.
- Storage and running sum:
  - Window is a circular buffer of L entries, indexed by a log2(L)-bit write pointer that wraps from L-1 to 0.
  - On accept, the oldest entry (at the pointer) is replaced by in_sample and the pointer advances.
  - Running sum updates as sum + in_sample - oldest, with both operands sign-extended.
  - Sum register width is WIDTH+log2(L) bits, signed, so the sum never overflows.
- Average:
  - avg = sum_new >>> log2(L), an arithmetic shift, i.e. floor toward negative infinity (e.g. 14/4 -> 3, -14/4 -> -4).
  - The result always fits in WIDTH bits; out_avg takes the low WIDTH bits.
- Latency:
  - out_avg and out_valid are registered at the same posedge that accepts the sample.
  - They are visible the cycle after in_valid is sampled high, which is 1-cycle latency.
- Warm-up:
  - A saturating fill counter (0..L) increments per accept.
  - out_valid=1 only for accepts that bring the count to L or find it already at L. The first L-1 accepts produce no output.
  - During warm-up out_avg is not updated and keeps its prior value (0 after reset).
- Steady state: one out_valid pulse per accepted sample; back-to-back accepts give back-to-back pulses.
- out_avg holds its last value while out_valid=0.
- rst has priority over in_valid in the same cycle.

Decomposition:
- No shared package required.
- Derived local constants: LOG2L = $clog2(L) and SUMW = WIDTH+LOG2L.
- One natural sub-module: sliding_window_ring.
  - Contents: L-deep, WIDTH-wide circular buffer with write pointer.
  - Interface: returns the oldest entry combinationally and writes on accept, with synchronous clear.
- Accumulator, fill counter and output register stay in the top.

Test Plan:
- Reset then stream 2,3,4,5,6,7,8 (L=4), one sample every other cycle -> no out_valid for 2,3,4. Exactly four pulses with out_avg = 3 (after 5), 4 (after 6), 5 (after 7), 6 (after 8). Each pulse is one cycle after the accepting edge.
- Same sequence driven back-to-back (in_valid held high 7 cycles) -> pulses on 4 consecutive cycles, with out_avg 3,4,5,6.
- Negative values: stream -2,-3,-4,-5 -> single out_valid with out_avg = -4 (sum -14, floor).
- Extremes at WIDTH=32: four samples of 2147483647, then four of -2147483648 -> out_avg = 2147483647, then after the window fully turns over -2147483648. No wraparound in between.
- Reset asserted after 2 samples, then stream 10,20,30,40 -> no pulse until 40. out_avg = 25, so no contribution from pre-reset samples.
- in_valid low for many idle cycles between samples -> out_valid stays 0 and out_avg holds. Results match the gap-free sequence.

Source files
------------

// File: rtl/sliding_window_pkg.sv
// sliding_window_pkg: shared helpers for the sliding-window averager.
//   is_pow2(n) - true when n is a positive power of two; used to reject
//                illegal window lengths at elaboration.
package sliding_window_pkg;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sliding_window_ring.sv
// sliding_window_ring: L-deep circular buffer of WIDTH-bit samples.
//   clk     - rising-edge clock
//   rst     - synchronous active-high clear (all slots and pointer to 0)
//   wr_en   - accept: overwrite the slot at the pointer, then advance it
//   wr_data - sample to store
//   oldest  - combinational view of the slot about to be overwritten
module sliding_window_ring #(
  parameter int WIDTH = 32,
  parameter int L     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] oldest
);

  localparam int LOG2L = $clog2(L);

  logic [L-1:0][WIDTH-1:0] mem_q;
  logic [LOG2L-1:0]        ptr_q;

  // L is a power of two, so the pointer wraps L-1 -> 0 by plain overflow.
  assign oldest = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      ptr_q <= '0;
    end else if (wr_en) begin
      mem_q[ptr_q] <= wr_data;
      ptr_q        <= ptr_q + LOG2L'(1);
    end
  end

endmodule

// File: rtl/sliding_window.sv
// sliding_window: streaming moving average over the last L signed samples.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset; discards all history
//   in_valid  - in_sample accepted on every cycle this is high
//   in_sample - signed two's-complement sample
//   out_valid - one-cycle pulse, out_avg carries a new mean
//   out_avg   - registered window mean, floor(sum / L); holds otherwise
module sliding_window
  import sliding_window_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int L     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_sample,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_avg
);

  localparam int LOG2L = $clog2(L);
  localparam int SUMW  = WIDTH + LOG2L;
  localparam logic [LOG2L:0] FULL = (LOG2L + 1)'(L);

  if (L < 2 || !is_pow2(L)) begin : g_bad_l
    $error("sliding_window: L must be a power of two and >= 2");
  end

  logic [WIDTH-1:0]       oldest;
  logic signed [SUMW-1:0] sum_q, sum_new, in_ext, old_ext;
  logic [LOG2L:0]         fill_q;
  logic                   window_full;

  sliding_window_ring #(.WIDTH(WIDTH), .L(L)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_sample),
    .oldest  (oldest)
  );

  // Slots start at 0, so subtracting the "oldest" during warm-up is harmless
  // and the running sum is always the exact sum of the last L accepts.
  assign in_ext  = {{LOG2L{in_sample[WIDTH-1]}}, in_sample};
  assign old_ext = {{LOG2L{oldest[WIDTH-1]}}, oldest};
  assign sum_new = sum_q + in_ext - old_ext;

  // This accept completes (or keeps) a full window.
  assign window_full = (fill_q >= FULL - (LOG2L + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        sum_q <= sum_new;
        if (fill_q != FULL) fill_q <= fill_q + (LOG2L + 1)'(1);
        if (window_full) begin
          out_valid <= 1'b1;
          // Arithmetic shift floors toward -inf; the mean always fits WIDTH.
          out_avg   <= WIDTH'(sum_new >>> LOG2L);
        end
      end
    end
  end

endmodule

// File: tb/tb_sliding_window.sv
module tb_sliding_window;

  localparam int WIDTH = 32;
  localparam int L     = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] in_sample = '0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_avg;

  int tests = 0;
  int fails = 0;

  logic signed [WIDTH-1:0] exp_q[$];
  logic signed [WIDTH-1:0] hold_exp = '0;
  bit                      mon_en = 1'b0;

  sliding_window #(.WIDTH(WIDTH), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .out_valid (out_valid),
    .out_avg   (out_avg)
  );

  always #5 clk = ~clk;

  // Monitor: sample on the falling edge, pop expected on each pulse,
  // otherwise out_avg must hold its last reported value.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: out_avg=%0d, required no out_valid", out_avg);
        end else begin
          logic signed [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_avg !== e) begin
            fails++;
            $display("FAIL avg: got %0d, required %0d", out_avg, e);
          end
          hold_exp = e;
        end
      end else if (out_valid !== 1'b0 || out_avg !== hold_exp) begin
        fails++;
        $display("FAIL hold: out_valid=%b out_avg=%0d, required 0 / %0d",
                 out_valid, out_avg, hold_exp);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hold_exp = '0;
  endtask

  task automatic send(input logic signed [WIDTH-1:0] v, input bit ev,
                      input logic signed [WIDTH-1:0] ea);
    in_valid  = 1'b1;
    in_sample = v;
    if (ev) exp_q.push_back(ea);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d pulses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  localparam logic signed [WIDTH-1:0] MAXV = 32'sh7FFF_FFFF;
  localparam logic signed [WIDTH-1:0] MINV = 32'sh8000_0000;

  initial begin
    do_reset();
    mon_en = 1'b1;

    // Reset state.
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_avg !== '0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b out_avg=%0d, required 0 / 0", out_valid, out_avg);
    end
    @(posedge clk); #1;

    // 2..8, one sample every other cycle.
    send(2, 0, 0); idle(1);
    send(3, 0, 0); idle(1);
    send(4, 0, 0); idle(1);
    send(5, 1, 3); idle(1);
    send(6, 1, 4); idle(1);
    send(7, 1, 5); idle(1);
    send(8, 1, 6); idle(1);
    drain("spaced");

    // Same sequence back-to-back.
    do_reset();
    send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    send(5, 1, 3); send(6, 1, 4); send(7, 1, 5); send(8, 1, 6);
    drain("b2b");

    // Negative values: sum -14 floors to -4.
    do_reset();
    send(-2, 0, 0); send(-3, 0, 0); send(-4, 0, 0); send(-5, 1, -4);
    drain("neg");

    // Extremes; window turns over from max to min.
    do_reset();
    send(MAXV, 0, 0); send(MAXV, 0, 0); send(MAXV, 0, 0); send(MAXV, 1, MAXV);
    send(MINV, 1, 32'sd1073741823);
    send(MINV, 1, -32'sd1);
    send(MINV, 1, -32'sd1073741825);
    send(MINV, 1, MINV);
    drain("extreme");

    // Reset mid-stream discards history.
    do_reset();
    send(100, 0, 0); send(200, 0, 0);
    do_reset();
    send(10, 0, 0); send(20, 0, 0); send(30, 0, 0); send(40, 1, 25);
    drain("midreset");

    // rst wins over in_valid in the same cycle.
    rst = 1'b1; in_valid = 1'b1; in_sample = 999;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; hold_exp = '0;
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 1, 1);
    drain("rst_prio");

    // Long idle gaps: same results as gap-free.
    do_reset();
    send(2, 0, 0); idle(6);
    send(3, 0, 0); idle(6);
    send(4, 0, 0); idle(6);
    send(5, 1, 3); idle(6);
    send(6, 1, 4); idle(6);
    send(7, 1, 5); idle(6);
    send(8, 1, 6); idle(6);
    drain("gaps");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
